// File: rtl/noc_pkg.sv
// Shared definitions for the router output-port logic.
//   - flit type codes carried in the top FLIT_TYPE_W bits of every flit
//   - arbiter state encoding
package noc_pkg;

  // The flit type sits in bits [flit_width-1 : flit_width-FLIT_TYPE_W].
  localparam int FLIT_TYPE_W = 2;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/flit_arbiter_4x1_mux.sv
// mux_flit_4x1: four-to-one flit datapath multiplexer.
// Ports:
//   d0..d3  in  flit_width : candidate flits, ports 0..3
//   sel     in  2          : port index to pass through
//   q       out flit_width : selected flit
module mux_flit_4x1 #(
  parameter int flit_width = 12
) (
  input  logic [flit_width-1:0] d0,
  input  logic [flit_width-1:0] d1,
  input  logic [flit_width-1:0] d2,
  input  logic [flit_width-1:0] d3,
  input  logic [1:0]            sel,
  output logic [flit_width-1:0] q
);

  always_comb begin
    case (sel)
      2'd0:    q = d0;
      2'd1:    q = d1;
      2'd2:    q = d2;
      default: q = d3;
    endcase
  end

endmodule

// File: rtl/flit_arbiter_4x1.sv
// flit_arbiter_4x1: round-robin, wormhole-locking arbiter for one router
// output. Picks one of four input ports, holds that choice from head to tail
// flit, and registers the chosen flit into a one-entry valid/ready stage.
//
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   flit1..flit4    : input flits, ports 0..3
//   in_valid[3:0]   : per-port flit valid
//   in_ready[3:0]   : per-port accept, one-hot or zero (combinational)
//   out_flit        : registered output flit
//   out_valid       : out_flit holds a flit
//   out_ready       : downstream takes out_flit this cycle
//   select[1:0]     : current mux select (combinational)
//   locked          : a packet is in progress
//   err             : one-cycle pulse after a body/tail is accepted in IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no packet open; round-robin pick starting at ptr
// LOCKED | head accepted from owner; only owner is served until tail/single
module flit_arbiter_4x1
  import noc_pkg::*;
#(
  parameter int flit_width = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [flit_width-1:0] flit1,
  input  logic [flit_width-1:0] flit2,
  input  logic [flit_width-1:0] flit3,
  input  logic [flit_width-1:0] flit4,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ready,
  output logic [flit_width-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            select,
  output logic                  locked,
  output logic                  err
);

  localparam int TYPE_LSB = flit_width - FLIT_TYPE_W;

  arb_state_e state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] owner, owner_nxt;
  logic       err_nxt;

  logic [flit_width-1:0]  mux_flit;
  logic [FLIT_TYPE_W-1:0] acc_type;
  logic [2:0]             pick;
  logic                   can_accept;
  logic                   accept;

  // Returns {found, index}: first requester scanning start, start+1, ... mod 4.
  // Scanning downwards lets the lowest offset overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  mux_flit_4x1 #(.flit_width(flit_width)) u_mux (
    .d0  (flit1),
    .d1  (flit2),
    .d2  (flit3),
    .d3  (flit4),
    .sel (select),
    .q   (mux_flit)
  );

  assign pick       = rr_pick(in_valid, ptr);
  assign can_accept = ~out_valid | out_ready;
  assign accept     = |in_ready;
  assign acc_type   = mux_flit[flit_width-1:TYPE_LSB];
  assign locked     = (state == LOCKED);

  // State register plus the arbitration context it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      err   <= err_nxt;
    end
  end

  // Next state. A stray body/tail in IDLE is forwarded as a one-flit packet,
  // so it advances the pointer exactly like a single.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    err_nxt   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (acc_type == FLIT_HEAD) begin
            state_nxt = LOCKED;
            owner_nxt = select;
          end else begin
            ptr_nxt = select + 2'd1;
            err_nxt = (acc_type == FLIT_BODY) || (acc_type == FLIT_TAIL);
          end
        end
        LOCKED: begin
          if ((acc_type == FLIT_TAIL) || (acc_type == FLIT_SINGLE)) begin
            state_nxt = IDLE;
            ptr_nxt   = owner + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs. Gated by rst_n so that ready/select read zero while reset is
  // held, even if requesters are already asserting valid.
  always_comb begin
    select   = 2'd0;
    in_ready = 4'b0000;
    if (rst_n) begin
      if (state == LOCKED) begin
        select = owner;
        if (in_valid[owner] && can_accept) in_ready[owner] = 1'b1;
      end else begin
        select = pick[2] ? pick[1:0] : ptr;
        if (pick[2] && can_accept) in_ready[pick[1:0]] = 1'b1;
      end
    end
  end

  // One-entry output stage; a drain and a new accept in the same cycle keep
  // out_valid high and replace the flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flit  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_flit  <= mux_flit;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flit_arbiter_4x1.sv
// Bench for flit_arbiter_4x1: per-port flit queues feed the DUT, a packet-level
// reference model predicts grants, lock, err and output occupancy every cycle,
// and a separate monitor matches each drained output flit against a scoreboard.
module tb_flit_arbiter_4x1;
  localparam int W = 12;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] flit1, flit2, flit3, flit4;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] out_flit;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   select;
  logic         locked;
  logic         err;

  always #5 clk = ~clk;

  flit_arbiter_4x1 #(.flit_width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit1     (flit1),
    .flit2     (flit2),
    .flit3     (flit3),
    .flit4     (flit4),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .select    (select),
    .locked    (locked),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] pq [4][$];   // flits waiting at each input port
  logic [W-1:0] exp_q [$];   // accepted flits not yet drained downstream
  int           grant_log [$];

  // Reference model: packet-level view of the output port.
  bit m_locked, m_ov, m_err;
  int m_owner, m_ptr;

  int         vp = 100, rp = 100;
  logic [3:0] hold_off = 4'b0000;
  int         seq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int log_at(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int p);
    logic [W-1:0] f;
    f = {t, 2'(p), 8'(seq)};
    seq++;
    return f;
  endfunction

  task automatic gen_pkt(input int p, input int kind);
    int nb;
    case (kind)
      0: pq[p].push_back(mk(T_SINGLE, p));
      1: begin
        nb = $urandom_range(3);
        pq[p].push_back(mk(T_HEAD, p));
        for (int b = 0; b < nb; b++) pq[p].push_back(mk(T_BODY, p));
        pq[p].push_back(mk(T_TAIL, p));
      end
      2: pq[p].push_back(mk(T_BODY, p));
      default: pq[p].push_back(mk(T_TAIL, p));
    endcase
  endtask

  function automatic bit all_empty();
    return pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_ov = 0; m_err = 0; m_owner = 0; m_ptr = 0;
  endtask

  // One clock cycle: drive at negedge, check combinational and registered
  // outputs against the model, then advance the model.
  task automatic cycle();
    logic [W-1:0] fl [4];
    logic [W-1:0] f;
    logic [1:0]   t;
    int win, fv, exp_sel;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = (pq[i].size() > 0) && !hold_off[i] && ($urandom_range(99) < vp);
      fl[i] = in_valid[i] ? pq[i][0] : W'($urandom);
    end
    flit1 = fl[0]; flit2 = fl[1]; flit3 = fl[2]; flit4 = fl[3];
    out_ready = ($urandom_range(99) < rp);
    #1;
    check("out_valid", out_valid, m_ov);
    check("locked", locked, m_locked);
    check("err", err, m_err);

    fv = -1;
    for (int k = 0; k < 4; k++)
      if (fv < 0 && in_valid[(m_ptr + k) % 4]) fv = (m_ptr + k) % 4;
    exp_sel = m_locked ? m_owner : ((fv >= 0) ? fv : m_ptr);
    win = -1;
    if (!m_ov || out_ready) begin
      if (m_locked) win = in_valid[m_owner] ? m_owner : -1;
      else          win = fv;
    end
    check("select", select, exp_sel);
    check("in_ready", in_ready, (win >= 0) ? (32'd1 << win) : 32'd0);

    m_err = 0;
    if (win >= 0) begin
      f = pq[win].pop_front();
      exp_q.push_back(f);
      grant_log.push_back(win);
      t = f[W-1 -: 2];
      if (!m_locked) begin
        if (t == T_HEAD) begin
          m_locked = 1; m_owner = win;
        end else begin
          m_ptr = (win + 1) % 4;
          m_err = (t == T_BODY) || (t == T_TAIL);
        end
      end else if (t == T_TAIL || t == T_SINGLE) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % 4;
      end
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_empty(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!all_empty() && n < max_cycles) begin
      cycle();
      n++;
    end
    if (!all_empty()) begin
      errors++;
      checks++;
      $display("FAIL %s: input queues not drained after %0d cycles", name, max_cycles);
    end
    run(2);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #3;
    in_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_select", select, 0);
    check("rst_in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) pq[i].delete();
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_in_ready", in_ready, 0);
    check("rst_hold_out_valid", out_valid, 0);
    @(negedge clk);
    #3;
    in_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  // Monitor: a transfer happens at the next posedge when out_valid & out_ready.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL out_flit: got %0h with no flit expected", out_flit);
        end else begin
          e = exp_q.pop_front();
          check("out_flit", out_flit, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 4'h0; out_ready = 1'b0;
    flit1 = '0; flit2 = '0; flit3 = '0; flit4 = '0;
    model_reset();
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_out_flit", out_flit, 0);
    check("init_in_ready", in_ready, 0);
    check("init_select", select, 0);
    #22;
    rst_n = 1'b1;

    // Idle after reset: nothing valid, nothing granted.
    run(3);

    // Fairness with continuous singles on every port.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) pq[i].push_back(W'(12'hC01 + i));
    grant_log.delete();
    run_until_empty("fairness", 20);
    for (int k = 0; k < 8; k++) check("fair_order", log_at(k), k % 4);

    // Wormhole lock: move the pointer to port 2, then port 2 sends a packet
    // while port 0 is valid the whole time.
    pq[1].push_back(12'hC20);
    run(2);
    grant_log.delete();
    pq[2].push_back(12'h4AA); pq[2].push_back(12'h0AB); pq[2].push_back(12'h8AC);
    pq[0].push_back(12'hC10); pq[0].push_back(12'hC11);
    run_until_empty("wormhole", 20);
    check("worm_g0", log_at(0), 2);
    check("worm_g1", log_at(1), 2);
    check("worm_g2", log_at(2), 2);
    check("worm_g3", log_at(3), 0);

    // Backpressure: five cycles with out_ready low while out_valid is high.
    for (int i = 0; i < 4; i++) begin
      gen_pkt(i, 0); gen_pkt(i, 0); gen_pkt(i, 0);
    end
    run(2);
    rp = 0;
    run(5);
    rp = 100;
    run_until_empty("backpressure", 30);

    // Stray body in IDLE from port 1: forwarded, err pulse, pointer to 2.
    pq[1].push_back(12'h012);
    run(3);
    grant_log.delete();
    for (int i = 0; i < 4; i++) gen_pkt(i, 0);
    run_until_empty("proto_err", 20);
    check("err_ptr_next", log_at(0), 2);

    // Owner stall: port 3 opens a packet then drops valid for three cycles.
    pq[3].push_back(12'h4D0); pq[3].push_back(12'h0D1);
    pq[3].push_back(12'h0D2); pq[3].push_back(12'h8D3);
    run(1);
    for (int i = 0; i < 3; i++) gen_pkt(i, 0);
    grant_log.delete();
    hold_off = 4'b1000;
    run(3);
    check("stall_no_grant", grant_log.size(), 0);
    hold_off = 4'b0000;
    run_until_empty("owner_stall", 20);
    check("stall_g0", log_at(0), 3);
    check("stall_g2", log_at(2), 3);
    check("stall_next", log_at(3), 0);

    // Reset in the middle of a locked packet; next arbitration starts at port 0.
    pq[2].push_back(12'h4E0);
    for (int b = 0; b < 4; b++) pq[2].push_back(W'(12'h0E1 + b));
    pq[2].push_back(12'h8E5);
    pq[1].push_back(12'hCE6);
    run(3);
    do_reset_mid();
    grant_log.delete();
    for (int i = 3; i >= 0; i--) gen_pkt(i, 0);
    run_until_empty("post_reset", 20);
    check("post_reset_first", log_at(0), 0);

    // Randomized traffic with random valid and ready.
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(9);
      gen_pkt($urandom_range(3), (r < 4) ? 0 : (r < 9) ? 1 : 2 + $urandom_range(1));
    end
    vp = 60; rp = 60;
    run_until_empty("random", 8000);

    // Drain whatever is still in the output stage.
    vp = 100; rp = 100;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
